daa_requester: RTL and testbench
================================

DAA_REQUESTER -- requirements
Module: daa_requester

Interface
REQ-001 SHALL have parameter TIMEOUT, default 4096, max cycles daa_valid is held per request before error.
REQ-002 SHALL have parameter MODE_MUL, default 2'b01, daa_mode value driven for scalar multiplication.
REQ-003 SHALL have port clk  input  1  clock, rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port start  input  1  one-cycle request to run a key exchange.
REQ-006 SHALL have ports i_prime, i_a, i_b  input  256 each  curve modulus and coefficients.
REQ-007 SHALL have ports i_px, i_py  input  256 each  base point P.
REQ-008 SHALL have ports i_qx, i_qy  input  256 each  peer public point nP.
REQ-009 SHALL have port i_scalar  input  256  private scalar m.
REQ-010 SHALL have ports daa_mode  output 2, daa_valid  output 1, daa_pointx/daa_pointy/daa_prime/daa_a/daa_b/daa_mul  output 256 each  request to the point multiplier.
REQ-011 SHALL have ports i_daa_finished  input 1, i_daa_outputx/i_daa_outputy  input 256 each  multiplier response.
REQ-012 SHALL have ports busy  output 1, done  output 1, error  output 1.
REQ-013 SHALL have ports pub_x/pub_y  output 256 each  result mP; sec_x/sec_y  output 256 each  result mnP.

Function
REQ-014 SHALL implement states IDLE, REQ1, GAP, REQ2, DONE, ERR.
REQ-015 In IDLE, start sampled high SHALL latch all i_* operands and move to REQ1; start is ignored in every other state.
REQ-016 daa_valid SHALL be registered, high exactly in REQ1 and REQ2; daa_mode = MODE_MUL then, 2'b00 otherwise.
REQ-017 In REQ1 the request SHALL carry point (px,py), scalar m; in REQ2 point (qx,qy), scalar m; prime/a/b from latched copies.
REQ-018 Request payload SHALL be stable while daa_valid is high.
REQ-019 i_daa_finished sampled high in REQ1 SHALL capture i_daa_output{x,y} into pub_{x,y} on that edge and go to GAP; finished is treated as combinational from the responder (may be high in the first valid cycle).
REQ-020 GAP SHALL last exactly one cycle with daa_valid low, then go to REQ2.
REQ-021 i_daa_finished sampled high in REQ2 SHALL capture into sec_{x,y} and go to DONE.
REQ-022 DONE SHALL assert done for exactly one cycle, then go to IDLE; pub/sec hold until next capture.
REQ-023 i_daa_finished sampled outside REQ1/REQ2 SHALL be ignored.
REQ-024 A cycle counter SHALL clear on entering REQ1/REQ2 and increment each valid cycle; reaching TIMEOUT without finished SHALL go to ERR.
REQ-025 ERR SHALL drop daa_valid, hold error high, and return to IDLE only on start (which also starts a new exchange and clears error).
REQ-026 busy SHALL be high in REQ1, GAP, REQ2, DONE; low in IDLE and ERR.
REQ-027 Counter width SHALL be clog2(TIMEOUT+1); no wrap-around before TIMEOUT.

Reset
REQ-028 rst low SHALL force IDLE immediately, including mid-request, with daa_valid, done, error, busy = 0, daa_mode = 0, counter = 0.
REQ-029 Reset SHALL clear pub/sec and latched operands to 0.

Structure
REQ-030 Shared package daa_pkg SHALL hold state encoding, MODE_MUL constant, and 256-bit width constant.
REQ-031 Timeout counter SHALL be sub-module daa_req_timer (clear, enable, expired).

Verification
REQ-032 Stub responder finishes on 33rd valid cycle with x=32'hDFA978E7,y=32'hF6A1A9BB, then 65th with x=32'h888F3531,y=32'h71917832 -> pub/sec equal those zero-extended, one GAP cycle, done pulses once.
REQ-033 Responder asserts finished in first valid cycle of both requests -> done 5 cycles after start edge, both captures correct.
REQ-034 Responder never finishes, TIMEOUT=16 -> valid drops after 16 cycles, error=1, busy=0; next start clears error and reruns.
REQ-035 rst pulsed low mid-REQ2 -> all outputs 0 immediately, state IDLE, no done.
REQ-036 start re-asserted during REQ1 and stray finished in IDLE -> both ignored, latched operands unchanged.

Source files
------------

// File: rtl/daa_pkg.sv
// Shared definitions for the DAA point-multiplier requester.
//   state_t          : requester FSM states
//   WIDTH            : operand / coordinate width in bits
//   MODE_MUL_DEFAULT : daa_mode value that selects scalar multiplication
package daa_pkg;

    localparam int unsigned WIDTH = 256;

    localparam logic [1:0] MODE_MUL_DEFAULT = 2'b01;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_REQ1 = 3'd1,
        S_GAP  = 3'd2,
        S_REQ2 = 3'd3,
        S_DONE = 3'd4,
        S_ERR  = 3'd5
    } state_t;

endpackage

// File: rtl/daa_req_timer.sv
// Per-request watchdog for the DAA requester.
//   clk, rst : clock (rising edge), asynchronous active-low reset
//   clear    : hold the count at zero
//   enable   : count this cycle (a request is outstanding)
//   expired  : combinational; high in the cycle whose count step reaches LIMIT
module daa_req_timer #(
    parameter int unsigned LIMIT = 4096
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int unsigned CW = $clog2(LIMIT + 1);

    logic [CW-1:0] count;

    // Saturates at LIMIT so the counter can never wrap back below it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && (count != CW'(LIMIT))) begin
            count <= count + CW'(1);
        end
    end

    // Flagged one step early so the FSM leaves on the edge where the count reaches LIMIT.
    assign expired = enable && (count == CW'(LIMIT - 1));

endmodule

// File: rtl/daa_requester.sv
// Key-exchange sequencer: issues two scalar multiplications (m*P, then m*nP)
// to an external point multiplier and captures the results.
//   clk, rst                      : clock (rising edge), async active-low reset
//   start                         : one-cycle request to run an exchange
//   i_prime/i_a/i_b               : curve modulus and coefficients
//   i_px/i_py, i_qx/i_qy          : base point P, peer public point nP
//   i_scalar                      : private scalar m
//   daa_mode/daa_valid/daa_*      : request to the multiplier
//   i_daa_finished/i_daa_output*  : multiplier response (may be combinational)
//   busy/done/error               : status
//   pub_x/pub_y, sec_x/sec_y      : results mP and mnP
module daa_requester
    import daa_pkg::*;
#(
    parameter int unsigned TIMEOUT  = 4096,
    parameter logic [1:0]  MODE_MUL = MODE_MUL_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] i_prime,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic [WIDTH-1:0] i_px,
    input  logic [WIDTH-1:0] i_py,
    input  logic [WIDTH-1:0] i_qx,
    input  logic [WIDTH-1:0] i_qy,
    input  logic [WIDTH-1:0] i_scalar,
    output logic [1:0]       daa_mode,
    output logic             daa_valid,
    output logic [WIDTH-1:0] daa_pointx,
    output logic [WIDTH-1:0] daa_pointy,
    output logic [WIDTH-1:0] daa_prime,
    output logic [WIDTH-1:0] daa_a,
    output logic [WIDTH-1:0] daa_b,
    output logic [WIDTH-1:0] daa_mul,
    input  logic             i_daa_finished,
    input  logic [WIDTH-1:0] i_daa_outputx,
    input  logic [WIDTH-1:0] i_daa_outputy,
    output logic             busy,
    output logic             done,
    output logic             error,
    output logic [WIDTH-1:0] pub_x,
    output logic [WIDTH-1:0] pub_y,
    output logic [WIDTH-1:0] sec_x,
    output logic [WIDTH-1:0] sec_y
);

    state_t state, next_state;

    logic load, capture_pub, capture_sec;
    logic in_req, expired;

    logic [WIDTH-1:0] prime_q, a_q, b_q, px_q, py_q, qx_q, qy_q, m_q;

    logic       valid_q, busy_q, done_q, error_q;
    logic [1:0] mode_q;

    assign in_req = (state == S_REQ1) || (state == S_REQ2);

    // Held in clear whenever no request is outstanding, so every REQ1/REQ2 entry starts at zero.
    daa_req_timer #(
        .LIMIT (TIMEOUT)
    ) u_timer (
        .clk     (clk),
        .rst     (rst),
        .clear   (!in_req),
        .enable  (in_req),
        .expired (expired)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state  = state;
        load        = 1'b0;
        capture_pub = 1'b0;
        capture_sec = 1'b0;
        case (state)
            S_IDLE, S_ERR: begin
                if (start) begin
                    next_state = S_REQ1;
                    load       = 1'b1;
                end
            end
            S_REQ1: begin
                // A response in the same cycle as expiry still counts.
                if (i_daa_finished) begin
                    next_state  = S_GAP;
                    capture_pub = 1'b1;
                end else if (expired) begin
                    next_state = S_ERR;
                end
            end
            S_GAP: next_state = S_REQ2;
            S_REQ2: begin
                if (i_daa_finished) begin
                    next_state  = S_DONE;
                    capture_sec = 1'b1;
                end else if (expired) begin
                    next_state = S_ERR;
                end
            end
            S_DONE:  next_state = S_IDLE;
            default: next_state = S_IDLE;
        endcase
    end

    // Status outputs are registered from next_state so they line up with the state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q <= 1'b0;
            mode_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            error_q <= 1'b0;
        end else begin
            valid_q <= (next_state == S_REQ1) || (next_state == S_REQ2);
            mode_q  <= ((next_state == S_REQ1) || (next_state == S_REQ2)) ? MODE_MUL : 2'b00;
            busy_q  <= (next_state == S_REQ1) || (next_state == S_GAP) ||
                       (next_state == S_REQ2) || (next_state == S_DONE);
            done_q  <= (next_state == S_DONE);
            error_q <= (next_state == S_ERR);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prime_q <= '0;
            a_q     <= '0;
            b_q     <= '0;
            px_q    <= '0;
            py_q    <= '0;
            qx_q    <= '0;
            qy_q    <= '0;
            m_q     <= '0;
        end else if (load) begin
            prime_q <= i_prime;
            a_q     <= i_a;
            b_q     <= i_b;
            px_q    <= i_px;
            py_q    <= i_py;
            qx_q    <= i_qx;
            qy_q    <= i_qy;
            m_q     <= i_scalar;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pub_x <= '0;
            pub_y <= '0;
            sec_x <= '0;
            sec_y <= '0;
        end else begin
            if (capture_pub) begin
                pub_x <= i_daa_outputx;
                pub_y <= i_daa_outputy;
            end
            if (capture_sec) begin
                sec_x <= i_daa_outputx;
                sec_y <= i_daa_outputy;
            end
        end
    end

    // Payload is selected by the state register only, so it cannot change while valid is high.
    assign daa_pointx = (state == S_REQ2) ? qx_q : px_q;
    assign daa_pointy = (state == S_REQ2) ? qy_q : py_q;
    assign daa_prime  = prime_q;
    assign daa_a      = a_q;
    assign daa_b      = b_q;
    assign daa_mul    = m_q;

    assign daa_valid = valid_q;
    assign daa_mode  = mode_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign error     = error_q;

endmodule

// File: tb/tb_daa_requester.sv
// Directed testbench for daa_requester: a combinational stub multiplier, a
// second instance with TIMEOUT=16 for the watchdog path, and reset/ignore cases.
module tb_daa_requester;

    localparam logic [255:0] R1X = 256'hDFA978E7;
    localparam logic [255:0] R1Y = 256'hF6A1A9BB;
    localparam logic [255:0] R2X = 256'h888F3531;
    localparam logic [255:0] R2Y = 256'h71917832;
    localparam logic [255:0] R3X = 256'h1234_5678_0000_0001;
    localparam logic [255:0] R3Y = 256'h1234_5678_0000_0002;
    localparam logic [255:0] R4X = 256'h9ABC_DEF0_0000_0003;
    localparam logic [255:0] R4Y = 256'h9ABC_DEF0_0000_0004;
    localparam logic [255:0] SX  = 256'hBAD0_BAD0;
    localparam logic [255:0] TX  = 256'h7777_0001;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic start = 1'b0;
    logic start2 = 1'b0;
    logic fin2 = 1'b0;
    logic [255:0] i_prime = '0, i_a = '0, i_b = '0, i_px = '0, i_py = '0;
    logic [255:0] i_qx = '0, i_qy = '0, i_scalar = '0;

    logic [1:0]   daa_mode;
    logic         daa_valid, busy, done, error;
    logic [255:0] daa_pointx, daa_pointy, daa_prime, daa_a, daa_b, daa_mul;
    logic [255:0] pub_x, pub_y, sec_x, sec_y;

    logic [1:0]   t_mode;
    logic         t_valid, t_busy, t_done, t_error;
    logic [255:0] t_pointx, t_pointy, t_prime, t_a, t_b, t_mul;
    logic [255:0] t_pub_x, t_pub_y, t_sec_x, t_sec_y;
    logic [255:0] t_out = TX;

    // Stub responder state
    int unsigned  resp_mode = 0;   // 0: finish on 33rd/65th valid cycle, 1: immediate, 2: never
    logic         stray = 1'b0;
    logic         vclr = 1'b0;
    int unsigned  vcnt = 0;
    logic [255:0] exp_qx = '0;
    logic         fin;
    logic [255:0] rx, ry;

    int unsigned n_tests = 0;
    int unsigned n_fail = 0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (vclr) vcnt <= 0;
        else if (daa_valid) vcnt <= vcnt + 1;
    end

    always_comb begin
        fin = 1'b0;
        rx  = '0;
        ry  = '0;
        if (stray) begin
            fin = 1'b1;
            rx  = SX;
            ry  = SX;
        end else if (daa_valid) begin
            if (resp_mode == 0) fin = (vcnt == 32) || (vcnt == 64);
            else if (resp_mode == 1) fin = 1'b1;
            if (daa_pointx == exp_qx) begin
                rx = (resp_mode == 1) ? R4X : R2X;
                ry = (resp_mode == 1) ? R4Y : R2Y;
            end else begin
                rx = (resp_mode == 1) ? R3X : R1X;
                ry = (resp_mode == 1) ? R3Y : R1Y;
            end
        end
    end

    daa_requester u_dut (
        .clk(clk), .rst(rst), .start(start),
        .i_prime(i_prime), .i_a(i_a), .i_b(i_b), .i_px(i_px), .i_py(i_py),
        .i_qx(i_qx), .i_qy(i_qy), .i_scalar(i_scalar),
        .daa_mode(daa_mode), .daa_valid(daa_valid), .daa_pointx(daa_pointx),
        .daa_pointy(daa_pointy), .daa_prime(daa_prime), .daa_a(daa_a), .daa_b(daa_b),
        .daa_mul(daa_mul), .i_daa_finished(fin), .i_daa_outputx(rx), .i_daa_outputy(ry),
        .busy(busy), .done(done), .error(error),
        .pub_x(pub_x), .pub_y(pub_y), .sec_x(sec_x), .sec_y(sec_y)
    );

    daa_requester #(.TIMEOUT(16)) u_dut_to (
        .clk(clk), .rst(rst), .start(start2),
        .i_prime(i_prime), .i_a(i_a), .i_b(i_b), .i_px(i_px), .i_py(i_py),
        .i_qx(i_qx), .i_qy(i_qy), .i_scalar(i_scalar),
        .daa_mode(t_mode), .daa_valid(t_valid), .daa_pointx(t_pointx),
        .daa_pointy(t_pointy), .daa_prime(t_prime), .daa_a(t_a), .daa_b(t_b),
        .daa_mul(t_mul), .i_daa_finished(fin2), .i_daa_outputx(t_out), .i_daa_outputy(t_out),
        .busy(t_busy), .done(t_done), .error(t_error),
        .pub_x(t_pub_x), .pub_y(t_pub_y), .sec_x(t_sec_x), .sec_y(t_sec_y)
    );

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [255:0] op(input logic [31:0] k, input logic [31:0] field);
        return {8{k ^ field}};
    endfunction

    task automatic set_ops(input logic [31:0] k);
        i_prime  = op(k, 32'h0101_0101);
        i_a      = op(k, 32'h0202_0202);
        i_b      = op(k, 32'h0303_0303);
        i_px     = op(k, 32'h0404_0404);
        i_py     = op(k, 32'h0505_0505);
        i_qx     = op(k, 32'h0606_0606);
        i_qy     = op(k, 32'h0707_0707);
        i_scalar = op(k, 32'h0808_0808);
    endtask

    task automatic pulse_start();
        vclr  = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        vclr  = 1'b0;
    endtask

    int unsigned vc, dc, done_at;

    initial begin
        // Reset state
        repeat (2) tick();
        check("rst_valid", 256'(daa_valid), 256'(0));
        check("rst_mode", 256'(daa_mode), 256'(0));
        check("rst_busy", 256'(busy), 256'(0));
        check("rst_done", 256'(done), 256'(0));
        check("rst_error", 256'(error), 256'(0));
        check("rst_pub_x", pub_x, '0);
        check("rst_prime", daa_prime, '0);
        rst = 1'b1;
        tick();

        // Stub finishes on 33rd and 65th valid cycles
        set_ops(32'hA5A5_0000);
        exp_qx = op(32'hA5A5_0000, 32'h0606_0606);
        resp_mode = 0;
        pulse_start();
        vc = 0; dc = 0; done_at = 0;
        for (int n = 1; n <= 70; n++) begin
            if (daa_valid) vc++;
            if (done) begin dc++; done_at = n; end
            if (n == 1) begin
                check("r1_mode", 256'(daa_mode), 256'(2'b01));
                check("r1_busy", 256'(busy), 256'(1));
                check("r1_px", daa_pointx, op(32'hA5A5_0000, 32'h0404_0404));
                check("r1_py", daa_pointy, op(32'hA5A5_0000, 32'h0505_0505));
                check("r1_mul", daa_mul, op(32'hA5A5_0000, 32'h0808_0808));
                check("r1_prime", daa_prime, op(32'hA5A5_0000, 32'h0101_0101));
                check("r1_a", daa_a, op(32'hA5A5_0000, 32'h0202_0202));
                check("r1_b", daa_b, op(32'hA5A5_0000, 32'h0303_0303));
            end
            if (n == 33) check("r1_last_valid", 256'(daa_valid), 256'(1));
            if (n == 34) begin
                check("gap_valid", 256'(daa_valid), 256'(0));
                check("gap_mode", 256'(daa_mode), 256'(0));
                check("gap_busy", 256'(busy), 256'(1));
                check("gap_pub_x", pub_x, R1X);
                check("gap_pub_y", pub_y, R1Y);
            end
            if (n == 35) begin
                check("r2_valid", 256'(daa_valid), 256'(1));
                check("r2_qx", daa_pointx, op(32'hA5A5_0000, 32'h0606_0606));
                check("r2_qy", daa_pointy, op(32'hA5A5_0000, 32'h0707_0707));
                check("r2_mul", daa_mul, op(32'hA5A5_0000, 32'h0808_0808));
            end
            tick();
        end
        check("t1_valid_cycles", 256'(vc), 256'(65));
        check("t1_done_count", 256'(dc), 256'(1));
        check("t1_done_cycle", 256'(done_at), 256'(67));
        check("t1_pub_x", pub_x, R1X);
        check("t1_pub_y", pub_y, R1Y);
        check("t1_sec_x", sec_x, R2X);
        check("t1_sec_y", sec_y, R2Y);
        check("t1_idle_busy", 256'(busy), 256'(0));
        check("t1_idle_error", 256'(error), 256'(0));

        // Immediate finish: start cycle, REQ1, GAP, REQ2, then done in the 5th cycle
        resp_mode = 1;
        pulse_start();
        vc = 0; dc = 0; done_at = 0;
        for (int n = 1; n <= 8; n++) begin
            if (daa_valid) vc++;
            if (done) begin dc++; done_at = n; end
            tick();
        end
        check("t2_valid_cycles", 256'(vc), 256'(2));
        check("t2_done_count", 256'(dc), 256'(1));
        check("t2_done_cycle", 256'(done_at), 256'(4));
        check("t2_pub_x", pub_x, R3X);
        check("t2_pub_y", pub_y, R3Y);
        check("t2_sec_x", sec_x, R4X);
        check("t2_sec_y", sec_y, R4Y);

        // start re-asserted in REQ1 with new operands, then stray finished in IDLE
        resp_mode = 0;
        set_ops(32'h3C3C_0000);
        exp_qx = op(32'h3C3C_0000, 32'h0606_0606);
        pulse_start();
        vc = 0; dc = 0; done_at = 0;
        for (int n = 1; n <= 70; n++) begin
            if (daa_valid) vc++;
            if (done) begin dc++; done_at = n; end
            if (n == 3) begin
                set_ops(32'h0F0F_0000);
                start = 1'b1;
            end
            if (n == 4) start = 1'b0;
            if (n == 5) begin
                check("t3_keep_px", daa_pointx, op(32'h3C3C_0000, 32'h0404_0404));
                check("t3_keep_mul", daa_mul, op(32'h3C3C_0000, 32'h0808_0808));
                check("t3_keep_prime", daa_prime, op(32'h3C3C_0000, 32'h0101_0101));
            end
            if (n == 35) check("t3_keep_qx", daa_pointx, op(32'h3C3C_0000, 32'h0606_0606));
            tick();
        end
        check("t3_valid_cycles", 256'(vc), 256'(65));
        check("t3_done_cycle", 256'(done_at), 256'(67));
        check("t3_sec_x", sec_x, R2X);
        stray = 1'b1;
        dc = 0;
        for (int n = 0; n < 3; n++) begin
            tick();
            if (done || busy || daa_valid) dc++;
        end
        stray = 1'b0;
        check("t3_stray_activity", 256'(dc), 256'(0));
        check("t3_stray_pub_x", pub_x, R1X);
        check("t3_stray_sec_y", sec_y, R2Y);
        check("t3_idle_px", daa_pointx, op(32'h3C3C_0000, 32'h0404_0404));

        // Watchdog on the TIMEOUT=16 instance
        start2 = 1'b1;
        tick();
        start2 = 1'b0;
        vc = 0;
        for (int n = 1; n <= 30; n++) begin
            if (t_valid) vc++;
            tick();
        end
        check("t4_valid_cycles", 256'(vc), 256'(16));
        check("t4_error", 256'(t_error), 256'(1));
        check("t4_busy", 256'(t_busy), 256'(0));
        check("t4_valid", 256'(t_valid), 256'(0));
        check("t4_mode", 256'(t_mode), 256'(0));
        start2 = 1'b1;
        tick();
        start2 = 1'b0;
        check("t4_rerun_error", 256'(t_error), 256'(0));
        check("t4_rerun_valid", 256'(t_valid), 256'(1));
        check("t4_rerun_busy", 256'(t_busy), 256'(1));
        fin2 = 1'b1;
        dc = 0;
        for (int n = 0; n < 6; n++) begin
            if (t_done) dc++;
            tick();
        end
        fin2 = 1'b0;
        check("t4_rerun_done", 256'(dc), 256'(1));
        check("t4_rerun_pub", t_pub_x, TX);
        check("t4_rerun_sec", t_sec_y, TX);

        // Asynchronous reset in the middle of REQ2
        set_ops(32'h5A5A_0000);
        exp_qx = op(32'h5A5A_0000, 32'h0606_0606);
        pulse_start();
        repeat (39) tick();
        check("t5_pre_valid", 256'(daa_valid), 256'(1));
        check("t5_pre_qx", daa_pointx, op(32'h5A5A_0000, 32'h0606_0606));
        #2 rst = 1'b0;
        #1;
        check("t5_valid", 256'(daa_valid), 256'(0));
        check("t5_mode", 256'(daa_mode), 256'(0));
        check("t5_busy", 256'(busy), 256'(0));
        check("t5_done", 256'(done), 256'(0));
        check("t5_error", 256'(error), 256'(0));
        check("t5_pub_x", pub_x, '0);
        check("t5_sec_x", sec_x, '0);
        check("t5_px", daa_pointx, '0);
        check("t5_mul", daa_mul, '0);
        rst = 1'b1;
        dc = 0;
        for (int n = 0; n < 70; n++) begin
            tick();
            if (done || busy || daa_valid) dc++;
        end
        check("t5_no_activity", 256'(dc), 256'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
